if_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register of the 5-stage RV32 pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory with a req/gnt/rvalid handshake.
- Presents the fetched instruction to ID. Obeys stall_IFID and flush from the hazard unit, and takes the branch target on flush.

---
 rtl/if_stage_pkg.sv | 37 +++
 rtl/if_stage_if_id_reg.sv | 38 +++
 rtl/if_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the RV32 5-stage pipeline.
// Holds the datapath width, the default reset PC and bubble encoding, the
// instruction-fetch state encoding, the IF/ID register update select and
// the IF/ID bundle that is also consumed by id_stage.
package if_stage_pkg;

  localparam int unsigned       XLEN              = 32;
  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0]   NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

  // IDLE    : nothing outstanding on the instruction memory port
  // WAIT    : one request outstanding, its response is wanted
  // DISCARD : one request outstanding, its response must be dropped
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_LOAD,
    IFID_BUBBLE
  } ifid_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   sel        : IFID_HOLD keeps contents, IFID_LOAD takes d,
//                IFID_BUBBLE clears valid / instr but keeps pc and pc4
//   d          : bundle to load
//   q          : registered bundle presented to ID
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  ifid_sel_e sel,
  input  if_id_t    d,
  output if_id_t    q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
      q.pc    <= '0;
      q.pc4   <= 32'd4;
    end else begin
      unique case (sel)
        IFID_LOAD: q <= d;
        IFID_BUBBLE: begin
          q.valid <= 1'b0;
          q.instr <= NOP_INSTR;
        end
        default: ; // IFID_HOLD
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register.
// Owns the PC, issues single-outstanding requests on a req/gnt/rvalid
// instruction memory port, buffers one response while ID is stalled and
// redirects to redirect_pc on flush.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   stall_IFID                    : hold IF/ID (and PC unless a request is accepted)
//   flush, redirect_pc            : kill fetch, insert bubble, restart at redirect_pc
//   imem_req/imem_addr            : fetch request, address = pc_q
//   imem_gnt                      : request accepted this cycle
//   imem_rvalid/imem_rdata        : fetch response
//   valid_ID/instr_ID/pc_ID/pc4_ID: IF/ID register contents for decode
module if_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = if_stage_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = if_stage_pkg::NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_IFID,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_ID,
  output logic [XLEN-1:0] instr_ID,
  output logic [XLEN-1:0] pc_ID,
  output logic [XLEN-1:0] pc4_ID
);

  import if_stage_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;

  // One-entry hold buffer for a response that arrives while ID is stalled.
  logic            buf_valid_q;
  logic [XLEN-1:0] buf_instr_q;
  logic [XLEN-1:0] buf_pc_q;

  logic            fire;
  logic            resp_take;
  ifid_sel_e       ifid_sel;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_gnt;
  // A response is only usable in WAIT; flush drops it.
  assign resp_take = (state_q == WAIT) & imem_rvalid & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // rvalid while IDLE (stale or illegal) is ignored
        if (fire) state_d = WAIT;
      end
      WAIT: begin
        if (flush)            state_d = imem_rvalid ? IDLE : DISCARD;
        else if (imem_rvalid) state_d = IDLE;
      end
      DISCARD: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request and IF/ID update select
  always_comb begin
    // A full buffer blocks requests only while it stays full; on stall
    // release it drains into IF/ID this cycle, so the next fetch may issue.
    imem_req = (state_q == IDLE) & (~buf_valid_q | ~stall_IFID) & ~reset & ~flush;

    ifid_d.valid = 1'b1;
    ifid_d.instr = imem_rdata;
    ifid_d.pc    = req_pc_q;
    ifid_d.pc4   = pc_plus4(req_pc_q);

    if (flush) begin
      ifid_sel = IFID_BUBBLE;
    end else if (stall_IFID) begin
      ifid_sel = IFID_HOLD;
    end else if (buf_valid_q) begin
      ifid_sel     = IFID_LOAD;
      ifid_d.instr = buf_instr_q;
      ifid_d.pc    = buf_pc_q;
      ifid_d.pc4   = pc_plus4(buf_pc_q);
    end else if (resp_take) begin
      ifid_sel = IFID_LOAD;
    end else begin
      ifid_sel = IFID_BUBBLE;
    end
  end

  // PC, request PC and hold buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      if (flush)     pc_q <= redirect_pc;
      else if (fire) pc_q <= pc_plus4(pc_q);

      if (fire) req_pc_q <= pc_q;

      if (flush) begin
        buf_valid_q <= 1'b0;
      end else if (resp_take && stall_IFID) begin
        buf_valid_q <= 1'b1;
        buf_instr_q <= imem_rdata;
        buf_pc_q    <= req_pc_q;
      end else if (!stall_IFID) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .sel   (ifid_sel),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign valid_ID = ifid_q.valid;
  assign instr_ID = ifid_q.instr;
  assign pc_ID    = ifid_q.pc;
  assign pc4_ID   = ifid_q.pc4;

endmodule
